fc_result_collector: RTL and testbench
======================================

// Module: fc_result_collector
// PURPOSE
//  Receiver for the final fully-connected stage output stream (32-bit score +
//  1-cycle ready strobe per class). Captures one frame of NUM_CLASS scores,
//  tracks the running arg-max, and presents the winning emotion class to the
//  host with a valid/ack handshake. Buffered scores stay readable until ack.
// PARAMETERS
//  BIT        32  score width; signed two's complement (compare is signed)
//  NUM_CLASS  7   scores per frame (FER emotion classes)
//  CLS_W      3   index width; must satisfy 2**CLS_W >= NUM_CLASS
// PORTS
//  clk           in   1          clock, all logic rising-edge
//  rst_          in   1          synchronous reset, active-high
//  data_in       in   BIT        score word from FC stage
//  data_valid    in   1          word strobe (FC data_ready_out_fc), 1 word/cycle max
//  result_ack    in   1          host consumes result; 1-cycle pulse
//  rd_addr       in   CLS_W      score buffer read index
//  rd_data       out  BIT        buffer[rd_addr], registered, 1-cycle latency
//  result_valid  out  1          frame complete, outputs below stable
//  class_idx     out  CLS_W      index of maximum score
//  max_score     out  BIT        value of maximum score
//  overflow      out  1          sticky: word arrived while result held
//  busy          out  1          frame partially received (COLLECT, cnt>0)
// BEHAVIOUR
//  Reset (rst_=1 at edge): state=COLLECT, cnt=0, result_valid=0, class_idx=0,
//   max_score=0, overflow=0, busy=0, rd_data=0; buffer contents not cleared.
//  States: COLLECT, HOLD.
//  COLLECT, data_valid=1: buffer[cnt]<=data_in.
//   cnt==0: run_max<=data_in, run_idx<=0 (unconditional load).
//   cnt>0:  if $signed(data_in) > $signed(run_max) replace; strict >, so ties
//           keep the lower index.
//   cnt==NUM_CLASS-1: next edge -> HOLD, result_valid=1, class_idx/max_score
//   <= final max including this word, cnt<=0. Latency: result_valid high
//   1 cycle after the last word's strobe cycle.
//   Otherwise cnt<=cnt+1. busy = (cnt!=0) in COLLECT.
//  COLLECT, data_valid=0: hold everything (gaps of any length allowed).
//  HOLD: result_valid, class_idx, max_score, buffer frozen.
//   data_valid=1 and result_ack=0: word dropped, overflow<=1 (sticky).
//   result_ack=1: next edge -> COLLECT, result_valid=0. If data_valid=1 in
//   the same cycle, that word is accepted as index 0 of the next frame
//   (run_max/run_idx loaded, cnt<=1); overflow not set.
//  result_ack while COLLECT: ignored.
//  overflow clears only on reset.
//  rd_data <= buffer[rd_addr] every cycle in any state; rd_addr>=NUM_CLASS
//   returns 0. Write and read of same address in one cycle returns old value.
//  Reset mid-frame: partial frame discarded, cnt=0; next strobe is index 0.
//  Width: no arithmetic on scores beyond signed compare; no saturation.
// TESTING
//  T1 scores 5,-3,9,2,9,0,1 -> result_valid 1 cycle after 7th strobe,
//     class_idx=2, max_score=9 (tie at idx4 loses).
//  T2 all scores negative (-8,-2,-5,-9,-4,-7,-6) -> class_idx=1, max=-2
//     (signed compare; no zero-init artefact).
//  T3 strobes with random 0-5 cycle gaps, max at idx6=0x7FFFFFFF -> idx=6;
//     busy high from 1st strobe until result_valid.
//  T4 in HOLD send 2 strobes without ack -> overflow=1, result unchanged;
//     then ack+strobe same cycle -> cnt=1, next 6 strobes complete new frame.
//  T5 rst_ after 4 strobes -> all outputs zero; next 7 strobes form a
//     complete frame with correct arg-max.
//  T6 readback: after frame, rd_addr 0..6 -> rd_data equals captured words
//     1 cycle later; rd_addr=7 -> 0.

Source files
------------

// File: rtl/fc_result_collector.sv
// Collects one frame of signed class scores from the FC stage, tracks the running
// arg-max and holds the winning class for the host until it is acknowledged.
module fc_result_collector #(
  parameter int BIT       = 32,
  parameter int NUM_CLASS = 7,
  parameter int CLS_W     = 3
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [BIT-1:0]   data_in,
  input  logic             data_valid,
  input  logic             result_ack,
  input  logic [CLS_W-1:0] rd_addr,
  output logic [BIT-1:0]   rd_data,
  output logic             result_valid,
  output logic [CLS_W-1:0] class_idx,
  output logic [BIT-1:0]   max_score,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [CLS_W-1:0] LAST_IDX     = CLS_W'(NUM_CLASS - 1);
  localparam logic [CLS_W:0]   NUM_CLASS_EXT = (CLS_W + 1)'(NUM_CLASS);

  state_t           state_reg, state_next;
  logic [CLS_W-1:0] cnt_reg, cnt_next;
  logic [BIT-1:0]   run_max_reg, run_max_next;
  logic [CLS_W-1:0] run_idx_reg, run_idx_next;
  logic [CLS_W-1:0] class_idx_reg, class_idx_next;
  logic [BIT-1:0]   max_score_reg, max_score_next;
  logic             overflow_reg, overflow_next;
  logic [BIT-1:0]   rd_data_reg;

  logic             wr_en;
  logic [CLS_W-1:0] wr_addr;
  logic             take;
  logic [BIT-1:0]   cand_max;
  logic [CLS_W-1:0] cand_idx;

  logic [BIT-1:0] buffer_mem [NUM_CLASS];

  // First word of a frame always loads; later words replace only on strictly greater.
  assign take     = (cnt_reg == '0) || ($signed(data_in) > $signed(run_max_reg));
  assign cand_max = take ? data_in : run_max_reg;
  assign cand_idx = take ? cnt_reg : run_idx_reg;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    run_max_next   = run_max_reg;
    run_idx_next   = run_idx_reg;
    class_idx_next = class_idx_reg;
    max_score_next = max_score_reg;
    overflow_next  = overflow_reg;
    wr_en          = 1'b0;
    wr_addr        = cnt_reg;
    case (state_reg)
      COLLECT: begin
        if (data_valid) begin
          wr_en = 1'b1;
          if (cnt_reg == LAST_IDX) begin
            state_next     = HOLD;
            cnt_next       = '0;
            class_idx_next = cand_idx;
            max_score_next = cand_max;
          end else begin
            cnt_next     = cnt_reg + CLS_W'(1);
            run_max_next = cand_max;
            run_idx_next = cand_idx;
          end
        end
      end
      HOLD: begin
        if (result_ack) begin
          state_next = COLLECT;
          // A word arriving with the ack starts the next frame at index 0.
          if (data_valid) begin
            wr_en        = 1'b1;
            wr_addr      = '0;
            run_max_next = data_in;
            run_idx_next = '0;
            cnt_next     = CLS_W'(1);
          end
        end else if (data_valid) begin
          overflow_next = 1'b1;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_reg     <= COLLECT;
      cnt_reg       <= '0;
      run_max_reg   <= '0;
      run_idx_reg   <= '0;
      class_idx_reg <= '0;
      max_score_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      run_max_reg   <= run_max_next;
      run_idx_reg   <= run_idx_next;
      class_idx_reg <= class_idx_next;
      max_score_reg <= max_score_next;
      overflow_reg  <= overflow_next;
    end
  end

  // Score buffer: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buffer_mem[wr_addr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      rd_data_reg <= '0;
    end else if ({1'b0, rd_addr} < NUM_CLASS_EXT) begin
      rd_data_reg <= buffer_mem[rd_addr];
    end else begin
      rd_data_reg <= '0;
    end
  end

  assign rd_data      = rd_data_reg;
  assign result_valid = (state_reg == HOLD);
  assign class_idx    = class_idx_reg;
  assign max_score    = max_score_reg;
  assign overflow     = overflow_reg;
  assign busy         = (state_reg == COLLECT) && (cnt_reg != '0);

endmodule

// File: tb/tb_fc_result_collector.sv
// Randomized self-checking bench for fc_result_collector with a frame-level
// arg-max reference model.
module tb_fc_result_collector;
  localparam int NC = 7;

  logic        clk = 1'b0;
  logic        rst_ = 1'b1;
  logic [31:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic        result_ack = 1'b0;
  logic [2:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        result_valid;
  logic [2:0]  class_idx;
  logic [31:0] max_score;
  logic        overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int n_frame = 0;
  logic [31:0] frame [NC];

  fc_result_collector #(.BIT(32), .NUM_CLASS(NC), .CLS_W(3)) dut (
    .clk(clk), .rst_(rst_), .data_in(data_in), .data_valid(data_valid),
    .result_ack(result_ack), .rd_addr(rd_addr), .rd_data(rd_data),
    .result_valid(result_valid), .class_idx(class_idx), .max_score(max_score),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: lowest index holding the largest signed value of the frame.
  function automatic int ref_idx();
    int best = 0;
    for (int i = 1; i < NC; i++)
      if ($signed(frame[i]) > $signed(frame[best])) best = i;
    return best;
  endfunction

  function automatic logic [31:0] rnd_score();
    if ($urandom_range(0, 1) == 1) return 32'(int'($urandom_range(0, 6)) - 3);
    return $urandom;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [31:0] w);
    data_in = w;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
  endtask

  // Sends frame[start..NC-1] with random gaps, then checks the reported result.
  task automatic run_frame(input int start, input int max_gap, input bit ack_noise);
    int exp_i;
    for (int i = start; i < NC; i++) begin
      int gap;
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        result_ack = ack_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        result_ack = 1'b0;
        n_vec++;
        if (busy !== (i > 0)) begin
          n_err++;
          $display("FAIL busy_gap idx%0d: got %0b expected %0b", i, busy, (i > 0));
        end
      end
      n_vec++;
      if (result_valid !== 1'b0 || busy !== (i > 0)) begin
        n_err++;
        $display("FAIL pre_strobe idx%0d: valid=%0b busy=%0b expected valid=0 busy=%0b",
                 i, result_valid, busy, (i > 0));
      end
      strobe(frame[i]);
    end
    exp_i = ref_idx();
    n_frame++;
    n_vec++;
    if (result_valid !== 1'b1 || class_idx !== 3'(exp_i) || max_score !== frame[exp_i] || busy !== 1'b0) begin
      n_err++;
      $display("FAIL result frame%0d: valid=%0b idx=%0d max=%0d busy=%0b expected 1/%0d/%0d/0",
               n_frame, result_valid, class_idx, $signed(max_score), busy, exp_i, $signed(frame[exp_i]));
    end else begin
      $display("frame %0d: class_idx=%0d max_score=%0d", n_frame, class_idx, $signed(max_score));
    end
  endtask

  task automatic do_ack();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL ack: valid=%0b busy=%0b expected 0/0", result_valid, busy);
    end
  endtask

  task automatic readback();
    for (int a = 0; a < 8; a++) begin
      logic [31:0] exp_w;
      exp_w = (a < NC) ? frame[a] : 32'h0;
      rd_addr = 3'(a);
      tick();
      n_vec++;
      if (rd_data !== exp_w) begin
        n_err++;
        $display("FAIL readback addr%0d: got %h expected %h", a, rd_data, exp_w);
      end
    end
  endtask

  task automatic test_reset();
    rst_ = 1'b1;
    tick();
    tick();
    n_vec++;
    if (result_valid !== 1'b0 || class_idx !== 3'd0 || max_score !== 32'd0 ||
        overflow !== 1'b0 || busy !== 1'b0 || rd_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset: valid=%0b idx=%0d max=%h ovf=%0b busy=%0b rd=%h expected all 0",
               result_valid, class_idx, max_score, overflow, busy, rd_data);
    end
    rst_ = 1'b0;
  endtask

  task automatic test_fixed();
    int t1 [NC] = '{5, -3, 9, 2, 9, 0, 1};
    int t2 [NC] = '{-8, -2, -5, -9, -4, -7, -6};
    for (int i = 0; i < NC; i++) frame[i] = 32'(t1[i]);
    run_frame(0, 0, 1'b0);
    n_vec++;
    if (class_idx !== 3'd2 || max_score !== 32'd9) begin
      n_err++;
      $display("FAIL t1_tie: idx=%0d max=%0d expected 2/9", class_idx, $signed(max_score));
    end
    do_ack();
    for (int i = 0; i < NC; i++) frame[i] = 32'(t2[i]);
    run_frame(0, 0, 1'b0);
    n_vec++;
    if (class_idx !== 3'd1 || max_score !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL t2_negative: idx=%0d max=%0d expected 1/-2", class_idx, $signed(max_score));
    end
    readback();
    do_ack();
  endtask

  task automatic test_gaps();
    for (int i = 0; i < NC - 1; i++) frame[i] = $urandom & 32'h7FFF_FFFE;
    frame[NC-1] = 32'h7FFF_FFFF;
    run_frame(0, 5, 1'b1);
    n_vec++;
    if (class_idx !== 3'd6 || max_score !== 32'h7FFF_FFFF) begin
      n_err++;
      $display("FAIL t3_gaps: idx=%0d max=%h expected 6/7fffffff", class_idx, max_score);
    end
  endtask

  // Entered while holding the previous frame's result.
  task automatic test_overflow();
    int exp_i;
    exp_i = ref_idx();
    for (int k = 0; k < 2; k++) begin
      strobe($urandom);
      n_vec++;
      if (overflow !== 1'b1 || result_valid !== 1'b1 || class_idx !== 3'(exp_i) || max_score !== frame[exp_i]) begin
        n_err++;
        $display("FAIL overflow_drop%0d: ovf=%0b valid=%0b idx=%0d max=%h expected 1/1/%0d/%h",
                 k, overflow, result_valid, class_idx, max_score, exp_i, frame[exp_i]);
      end
    end
    readback();
    for (int i = 0; i < NC; i++) frame[i] = rnd_score();
    result_ack = 1'b1;
    strobe(frame[0]);
    result_ack = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0 || busy !== 1'b1 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ack_strobe: valid=%0b busy=%0b ovf=%0b expected 0/1/1", result_valid, busy, overflow);
    end
    run_frame(1, 2, 1'b0);
    n_vec++;
    if (overflow !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_sticky: got %0b expected 1", overflow);
    end
    readback();
    do_ack();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) strobe(rnd_score());
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL partial_busy: got %0b expected 1", busy);
    end
    rst_ = 1'b1;
    tick();
    rst_ = 1'b0;
    n_vec++;
    if (result_valid !== 1'b0 || class_idx !== 3'd0 || max_score !== 32'd0 ||
        overflow !== 1'b0 || busy !== 1'b0 || rd_data !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid: valid=%0b idx=%0d max=%h ovf=%0b busy=%0b rd=%h expected all 0",
               result_valid, class_idx, max_score, overflow, busy, rd_data);
    end
    for (int i = 0; i < NC; i++) frame[i] = rnd_score();
    run_frame(0, 1, 1'b0);
    readback();
    do_ack();
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int a;
      int exp_i;
      for (int i = 0; i < NC; i++) frame[i] = rnd_score();
      run_frame(0, 3, 1'b1);
      exp_i = ref_idx();
      a = int'($urandom_range(0, 7));
      rd_addr = 3'(a);
      tick();
      n_vec++;
      if (rd_data !== ((a < NC) ? frame[a] : 32'h0) || result_valid !== 1'b1 ||
          class_idx !== 3'(exp_i) || max_score !== frame[exp_i]) begin
        n_err++;
        $display("FAIL random_hold frame%0d addr%0d: rd=%h valid=%0b idx=%0d expected rd=%h idx=%0d",
                 n_frame, a, rd_data, result_valid, class_idx, (a < NC) ? frame[a] : 32'h0, exp_i);
      end
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_gaps();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
